// File: rtl/ex_mem_pipe_pkg.sv
// ex_mem_pipe_pkg: shared widths, result-select encoding and buffered entry layout
package ex_mem_pipe_pkg;
  localparam int DW = 32;
  localparam int RW = 5;
  typedef enum logic [1:0] {
    RES_S     = 2'd0,
    RES_SLT   = 2'd1,
    RES_Z     = 2'd2,
    RES_S_ALT = 2'd3
  } res_sel_e;
  typedef struct packed {
    logic [DW-1:0] pc;
    logic [DW-1:0] result;
    logic [DW-1:0] wdata;
    logic [RW-1:0] rd;
    logic          regwr;
    logic          memrd;
    logic          memwr;
  } entry_t;
endpackage

// File: rtl/ex_mem_pipe_if.sv
// ex_mem_pipe_if: EX-side, MEM-side, flush and exception signals of the EX->MEM stage
interface ex_mem_pipe_if import ex_mem_pipe_pkg::*; ;
  logic          flush;
  logic          ex_valid;
  logic          ex_ready;
  logic [DW-1:0] ex_pc;
  logic [DW-1:0] alu_s;
  logic          alu_z;
  logic          alu_v;
  logic          alu_n;
  logic [1:0]    ex_res_sel;
  logic          ex_trap_en;
  logic [RW-1:0] ex_rd;
  logic          ex_regwr;
  logic          ex_memrd;
  logic          ex_memwr;
  logic [DW-1:0] ex_wdata;
  logic          mem_valid;
  logic          mem_ready;
  logic [DW-1:0] mem_pc;
  logic [DW-1:0] mem_result;
  logic [DW-1:0] mem_wdata;
  logic [RW-1:0] mem_rd;
  logic          mem_regwr;
  logic          mem_memrd;
  logic          mem_memwr;
  logic          exc_req;
  logic [DW-1:0] exc_epc;
  logic          exc_ack;
  modport master (
    output flush, ex_valid, ex_pc, alu_s, alu_z, alu_v, alu_n, ex_res_sel, ex_trap_en,
           ex_rd, ex_regwr, ex_memrd, ex_memwr, ex_wdata, mem_ready, exc_ack,
    input  ex_ready, mem_valid, mem_pc, mem_result, mem_wdata, mem_rd, mem_regwr,
           mem_memrd, mem_memwr, exc_req, exc_epc
  );
  modport slave (
    input  flush, ex_valid, ex_pc, alu_s, alu_z, alu_v, alu_n, ex_res_sel, ex_trap_en,
           ex_rd, ex_regwr, ex_memrd, ex_memwr, ex_wdata, mem_ready, exc_ack,
    output ex_ready, mem_valid, mem_pc, mem_result, mem_wdata, mem_rd, mem_regwr,
           mem_memrd, mem_memwr, exc_req, exc_epc
  );
endinterface

// File: rtl/ex_mem_pipe_result_fmt.sv
// ex_mem_pipe_result_fmt: selects the final result from the adder flags and flags signed overflow
module ex_mem_pipe_result_fmt
  import ex_mem_pipe_pkg::*;
(
  input  logic [DW-1:0] alu_s,
  input  logic          alu_z,
  input  logic          alu_n,
  input  logic          alu_v,
  input  logic [1:0]    sel,
  input  logic          trap_en,
  output logic [DW-1:0] result,
  output logic          ovf
);
  assign result = (sel == RES_SLT) ? {{(DW-1){1'b0}}, alu_n} :
                  (sel == RES_Z)   ? {{(DW-1){1'b0}}, alu_z} : alu_s;
  assign ovf = trap_en & alu_v;
endmodule

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX->MEM stage with 2-entry skid buffer, overflow exception capture and flush
module ex_mem_pipe
  import ex_mem_pipe_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  ex_mem_pipe_if.slave bus
);
  entry_t        head_q, head_d, skid_q, skid_d, new_e;
  logic [1:0]    occ_q, occ_d, rem;
  logic          exc_req_q, exc_req_d;
  logic [DW-1:0] exc_epc_q, exc_epc_d;
  logic [DW-1:0] result;
  logic          ovf, accept, push, pop;
  ex_mem_pipe_result_fmt u_fmt (
    .alu_s   (bus.alu_s),
    .alu_z   (bus.alu_z),
    .alu_n   (bus.alu_n),
    .alu_v   (bus.alu_v),
    .sel     (bus.ex_res_sel),
    .trap_en (bus.ex_trap_en),
    .result  (result),
    .ovf     (ovf)
  );
  assign bus.ex_ready   = (occ_q < 2'd2) & ~exc_req_q;
  assign bus.mem_valid  = occ_q != 2'd0;
  assign bus.mem_pc     = head_q.pc;
  assign bus.mem_result = head_q.result;
  assign bus.mem_wdata  = head_q.wdata;
  assign bus.mem_rd     = head_q.rd;
  assign bus.mem_regwr  = head_q.regwr;
  assign bus.mem_memrd  = head_q.memrd;
  assign bus.mem_memwr  = head_q.memwr;
  assign bus.exc_req    = exc_req_q;
  assign bus.exc_epc    = exc_epc_q;
  assign accept = bus.ex_valid & bus.ex_ready & ~bus.flush;
  assign push   = accept & ~ovf;
  assign pop    = bus.mem_valid & bus.mem_ready & ~bus.flush;
  assign rem    = occ_q - {1'b0, pop};
  assign new_e  = '{pc: bus.ex_pc, result: result, wdata: bus.ex_wdata, rd: bus.ex_rd,
                    regwr: bus.ex_regwr, memrd: bus.ex_memrd, memwr: bus.ex_memwr};
  // FIFO next state: pop shifts skid into head, push lands in the first free slot
  always_comb begin
    head_d = (pop && occ_q == 2'd2) ? skid_q : head_q;
    skid_d = skid_q;
    occ_d  = bus.flush ? 2'd0 : rem + {1'b0, push};
    if (push && rem == 2'd0) head_d = new_e;
    if (push && rem == 2'd1) skid_d = new_e;
  end
  // exception capture; a pending exception blocks accept so ack and new overflow never collide
  always_comb begin
    exc_req_d = (accept & ovf) | (exc_req_q & ~bus.exc_ack);
    exc_epc_d = (accept & ovf) ? bus.ex_pc : exc_epc_q;
  end
  // state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q    <= '0;
      skid_q    <= '0;
      occ_q     <= '0;
      exc_req_q <= 1'b0;
      exc_epc_q <= '0;
    end else begin
      head_q    <= head_d;
      skid_q    <= skid_d;
      occ_q     <= occ_d;
      exc_req_q <= exc_req_d;
      exc_epc_q <= exc_epc_d;
    end
  end
endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb_ex_mem_pipe: directed and randomized checks of ex_mem_pipe against a queue-based model
module tb_ex_mem_pipe;
  import ex_mem_pipe_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  ex_mem_pipe_if bus();
  ex_mem_pipe dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int n_tests = 0;
  int n_fail = 0;
  entry_t q[$];
  logic m_exc = 1'b0;
  logic [31:0] m_epc = '0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fmt(logic [1:0] sel, logic [31:0] s, logic z, logic n);
    return (sel == 2'd1) ? {31'b0, n} : (sel == 2'd2) ? {31'b0, z} : s;
  endfunction

  task automatic model_clear();
    q.delete();
    m_exc = 1'b0;
    m_epc = '0;
  endtask

  task automatic model_update();
    entry_t e;
    bit rdy, acc, ovf;
    rdy = (q.size() < 2) && !m_exc;
    acc = bus.ex_valid && rdy && !bus.flush;
    ovf = acc && bus.ex_trap_en && bus.alu_v;
    e.pc = bus.ex_pc;
    e.result = fmt(bus.ex_res_sel, bus.alu_s, bus.alu_z, bus.alu_n);
    e.wdata = bus.ex_wdata;
    e.rd = bus.ex_rd;
    e.regwr = bus.ex_regwr;
    e.memrd = bus.ex_memrd;
    e.memwr = bus.ex_memwr;
    if (bus.flush) q.delete();
    else begin
      if (q.size() > 0 && bus.mem_ready) void'(q.pop_front());
      if (acc && !ovf) q.push_back(e);
    end
    if (ovf) begin
      m_exc = 1'b1;
      m_epc = bus.ex_pc;
    end else if (bus.exc_ack) m_exc = 1'b0;
  endtask

  task automatic check_all();
    chk("ex_ready", bus.ex_ready, (q.size() < 2) && !m_exc);
    chk("mem_valid", bus.mem_valid, q.size() != 0);
    chk("exc_req", bus.exc_req, m_exc);
    chk("exc_epc", bus.exc_epc, m_epc);
    if (q.size() != 0) begin
      chk("mem_pc", bus.mem_pc, q[0].pc);
      chk("mem_result", bus.mem_result, q[0].result);
      chk("mem_wdata", bus.mem_wdata, q[0].wdata);
      chk("mem_rd", bus.mem_rd, q[0].rd);
      chk("mem_ctl", {bus.mem_regwr, bus.mem_memrd, bus.mem_memwr},
          {q[0].regwr, q[0].memrd, q[0].memwr});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(logic mr);
    bus.flush = 0; bus.ex_valid = 0; bus.ex_pc = '0; bus.alu_s = '0; bus.alu_z = 0;
    bus.alu_v = 0; bus.alu_n = 0; bus.ex_res_sel = 0; bus.ex_trap_en = 0; bus.ex_rd = '0;
    bus.ex_regwr = 0; bus.ex_memrd = 0; bus.ex_memwr = 0; bus.ex_wdata = '0;
    bus.mem_ready = mr; bus.exc_ack = 0;
  endtask

  task automatic push(logic [1:0] sel, logic [31:0] s, logic z, logic n, logic v,
                      logic trap, logic [31:0] pc);
    bus.ex_valid = 1; bus.ex_res_sel = sel; bus.alu_s = s; bus.alu_z = z; bus.alu_n = n;
    bus.alu_v = v; bus.ex_trap_en = trap; bus.ex_pc = pc;
    bus.ex_rd = 5'($urandom); bus.ex_wdata = $urandom;
    {bus.ex_regwr, bus.ex_memrd, bus.ex_memwr} = 3'($urandom);
  endtask

  initial begin
    idle(0);
    model_clear();
    repeat (2) @(negedge clk);
    chk("rst_mem_pc", bus.mem_pc, 32'h0);
    chk("rst_exc_epc", bus.exc_epc, 32'h0);
    reset = 1;
    tick();
    chk("rst_ready", bus.ex_ready, 1);
    // mid-stream reset
    push(0, 32'h55, 0, 0, 0, 0, 32'h100); tick();
    chk("pre_rst_valid", bus.mem_valid, 1);
    push(0, 32'h66, 0, 0, 0, 0, 32'h104); tick();
    idle(0);
    reset = 0;
    model_clear();
    #1;
    chk("async_rst_valid", bus.mem_valid, 0);
    chk("async_rst_exc", bus.exc_req, 0);
    chk("async_rst_result", bus.mem_result, 32'h0);
    @(negedge clk);
    reset = 1;
    tick();
    chk("post_rst_ready", bus.ex_ready, 1);
    // stream: back-to-back, one-cycle latency
    idle(1);
    push(0, 32'h11, 0, 0, 0, 0, 32'h200); tick(); chk("stream_a", bus.mem_result, 32'h11);
    push(3, 32'h22, 0, 0, 0, 0, 32'h204); tick(); chk("stream_b", bus.mem_result, 32'h22);
    push(0, 32'h33, 0, 0, 0, 0, 32'h208); tick(); chk("stream_c", bus.mem_result, 32'h33);
    idle(1); tick(); chk("stream_drain", bus.mem_valid, 0);
    // backpressure
    idle(0);
    push(0, 32'hA1, 0, 0, 0, 0, 32'h300); tick();
    push(0, 32'hB2, 0, 0, 0, 0, 32'h304); tick();
    chk("bp_ready", bus.ex_ready, 0); chk("bp_head", bus.mem_result, 32'hA1);
    idle(0); tick(); chk("bp_hold", bus.mem_result, 32'hA1);
    idle(1); tick(); chk("bp_second", bus.mem_result, 32'hB2); chk("bp_ready1", bus.ex_ready, 1);
    tick(); chk("bp_empty", bus.mem_valid, 0);
    // SLT / zero select
    push(1, 32'hFFFF_FFFE, 0, 1, 0, 0, 32'h400); tick(); chk("slt", bus.mem_result, 32'h1);
    push(2, 32'h0, 1, 0, 0, 0, 32'h404); tick(); chk("zsel", bus.mem_result, 32'h1);
    idle(1); tick();
    // overflow
    push(0, 32'h7, 0, 0, 1, 1, 32'h0040_0010); tick();
    chk("ovf_req", bus.exc_req, 1); chk("ovf_epc", bus.exc_epc, 32'h0040_0010);
    chk("ovf_noentry", bus.mem_valid, 0); chk("ovf_ready", bus.ex_ready, 0);
    push(0, 32'h8, 0, 0, 0, 0, 32'h500); tick();
    chk("ovf_hold", bus.exc_req, 1); chk("ovf_blocked", bus.mem_valid, 0);
    idle(1); bus.exc_ack = 1; tick();
    chk("ack_clear", bus.exc_req, 0); chk("ack_ready", bus.ex_ready, 1);
    // flush with full buffer
    idle(0);
    push(0, 32'hC1, 0, 0, 0, 0, 32'h600); tick();
    push(0, 32'hC2, 0, 0, 0, 0, 32'h604); tick();
    push(0, 32'hC3, 0, 0, 0, 0, 32'h608); bus.mem_ready = 1; bus.flush = 1; tick();
    chk("flush_valid", bus.mem_valid, 0); chk("flush_ready", bus.ex_ready, 1);
    // flush keeps a pending exception
    idle(0);
    push(0, 32'hD1, 0, 0, 0, 0, 32'h700); tick();
    push(0, 32'hD2, 0, 0, 1, 1, 32'h704); tick();
    chk("drain_during_exc", bus.mem_result, 32'hD1);
    idle(1); bus.flush = 1; tick();
    chk("flush_exc", bus.exc_req, 1); chk("flush_epc", bus.exc_epc, 32'h704);
    chk("flush_empty", bus.mem_valid, 0);
    idle(1); bus.exc_ack = 1; tick();
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      idle($urandom_range(9) < 6);
      if ($urandom_range(9) < 7)
        push(2'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom_range(7) == 0,
             1'($urandom), $urandom);
      bus.flush = $urandom_range(15) == 0;
      bus.exc_ack = $urandom_range(3) == 0;
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
